wb_peripheral_responder: RTL and testbench

Wishbone pipelined-mode responder that terminates bus cycles issued by the core-side Wishbone master and converts each one into a single access on a simple peripheral register/memory port. It sits between the SoC interconnect and one peripheral: it latches one request, drives the peripheral, and answers with exactly one ack or error. It also times out accesses to a peripheral that stays busy too long.

---
 rtl/wb_peripheral_responder_pkg.sv | 17 +
 rtl/wb_timeout_counter.sv | 27 ++
 rtl/wb_peripheral_responder.sv | 152 +++++++++++++++
 tb/tb_wb_peripheral_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_peripheral_responder_pkg.sv
// Shared Wishbone responder definitions: state encoding, payload widths and error read value.
package wb_peripheral_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'h0,
    ACCESS  = 2'h1,
    RESPOND = 2'h2,
    ERROR   = 2'h3
  } wb_state_t;

  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned SEL_WIDTH           = 4;
  localparam int unsigned TIMEOUT_COUNT_WIDTH = 8;

  localparam logic [DATA_WIDTH-1:0] ERROR_READ_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts busy cycles of one peripheral access and flags when the limit is reached.
module wb_timeout_counter
  import wb_peripheral_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_COUNT_WIDTH-1:0] count;

  // Holds at the limit so the flag stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TIMEOUT_COUNT_WIDTH'(1);
    end
  end

  assign expired = (count >= TIMEOUT_COUNT_WIDTH'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wb_peripheral_responder.sv
// Wishbone pipelined responder: one outstanding request mapped onto a simple peripheral
// register port, with address-range and busy-timeout error termination.
module wb_peripheral_responder
  import wb_peripheral_responder_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH            = 28,
  parameter int unsigned PERIPHERAL_ADDRESS_WIDTH = 24,
  parameter int unsigned TIMEOUT_CYCLES           = 255
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic                                wb_cyc_i,
  input  logic                                wb_stb_i,
  input  logic                                wb_we_i,
  input  logic [SEL_WIDTH-1:0]                wb_sel_i,
  input  logic [DATA_WIDTH-1:0]               wb_data_i,
  input  logic [ADDRESS_WIDTH-1:0]            wb_adr_i,
  output logic                                wb_ack_o,
  output logic                                wb_stall_o,
  output logic                                wb_error_o,
  output logic [DATA_WIDTH-1:0]               wb_data_o,
  output logic [PERIPHERAL_ADDRESS_WIDTH-1:0] peripheralAddress,
  output logic [SEL_WIDTH-1:0]                peripheralByteSelect,
  output logic                                peripheralWriteEnable,
  output logic                                peripheralReadEnable,
  output logic [DATA_WIDTH-1:0]               peripheralDataWrite,
  input  logic [DATA_WIDTH-1:0]               peripheralDataRead,
  input  logic                                peripheralBusy
);

  localparam int unsigned HIGH_WIDTH = ADDRESS_WIDTH - PERIPHERAL_ADDRESS_WIDTH;

  wb_state_t               state_q;
  wb_state_t               state_d;
  logic                    we_q;
  logic                    we_d;
  logic                    accept;
  logic                    capture;
  logic                    cnt_clear;
  logic                    cnt_en;
  logic                    expired;
  logic                    addr_oob;
  logic                    ack_d;
  logic                    err_d;
  logic                    wen_d;
  logic                    ren_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  // Any address bit beyond the decoded window is an unmapped access.
  generate
    if (HIGH_WIDTH > 0) begin : g_oob
      assign addr_oob = |wb_adr_i[ADDRESS_WIDTH-1:PERIPHERAL_ADDRESS_WIDTH];
    end else begin : g_no_oob
      assign addr_oob = 1'b0;
    end
  endgenerate

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the next values of every registered output.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    capture   = 1'b0;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          accept    = 1'b1;
          cnt_clear = 1'b1;
          state_d   = addr_oob ? ERROR : ACCESS;
        end
      end
      ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (!peripheralBusy) begin
          state_d = RESPOND;
          capture = !we_q;
        end else if (expired) begin
          state_d = ERROR;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    we_d  = accept ? wb_we_i : we_q;
    wen_d = (state_d == ACCESS) && we_d;
    ren_d = (state_d == ACCESS) && !we_d;
    ack_d = (state_d == RESPOND);
    err_d = (state_d == ERROR);

    rdata_d = wb_data_o;
    if (capture) begin
      rdata_d = peripheralDataRead;
    end
    if (err_d) begin
      rdata_d = ERROR_READ_VALUE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_q                  <= 1'b0;
      wb_ack_o              <= 1'b0;
      wb_error_o            <= 1'b0;
      wb_data_o             <= ERROR_READ_VALUE;
      peripheralAddress     <= '0;
      peripheralByteSelect  <= '0;
      peripheralDataWrite   <= '0;
      peripheralWriteEnable <= 1'b0;
      peripheralReadEnable  <= 1'b0;
    end else begin
      we_q                  <= we_d;
      wb_ack_o              <= ack_d;
      wb_error_o            <= err_d;
      wb_data_o             <= rdata_d;
      peripheralWriteEnable <= wen_d;
      peripheralReadEnable  <= ren_d;
      if (accept) begin
        peripheralAddress    <= wb_adr_i[PERIPHERAL_ADDRESS_WIDTH-1:0];
        peripheralByteSelect <= wb_sel_i;
        peripheralDataWrite  <= wb_data_i;
      end
    end
  end

  assign wb_stall_o = (state_q != IDLE);

endmodule

// File: tb/tb_wb_peripheral_responder.sv
// Directed self-checking bench for wb_peripheral_responder with a short timeout limit.
module tb_wb_peripheral_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [27:0] adr;
  logic        ack;
  logic        stall;
  logic        err;
  logic [31:0] rdata;
  logic [23:0] p_adr;
  logic [3:0]  p_sel;
  logic        p_wen;
  logic        p_ren;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_peripheral_responder #(
    .ADDRESS_WIDTH(28),
    .PERIPHERAL_ADDRESS_WIDTH(24),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i             (clk),
    .wb_rst_i             (rst),
    .wb_cyc_i             (cyc),
    .wb_stb_i             (stb),
    .wb_we_i              (we),
    .wb_sel_i             (sel),
    .wb_data_i            (wdata),
    .wb_adr_i             (adr),
    .wb_ack_o             (ack),
    .wb_stall_o           (stall),
    .wb_error_o           (err),
    .wb_data_o            (rdata),
    .peripheralAddress    (p_adr),
    .peripheralByteSelect (p_sel),
    .peripheralWriteEnable(p_wen),
    .peripheralReadEnable (p_ren),
    .peripheralDataWrite  (p_wdata),
    .peripheralDataRead   (p_rdata),
    .peripheralBusy       (p_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns in the first cycle after acceptance.
  task automatic issue(input logic w, input logic [27:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdata = d;
    step();
    stb = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) check("ack_err_exclusive", {31'b0, ack & err}, 32'h0);
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    wdata = 32'h0; adr = 28'h0; p_rdata = 32'h0; p_busy = 1'b0;
    step(); step();
    check("rst_ack",   {31'b0, ack},   32'h0);
    check("rst_err",   {31'b0, err},   32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_data",  rdata,          32'hFFFF_FFFF);
    check("rst_wen",   {31'b0, p_wen}, 32'h0);
    check("rst_ren",   {31'b0, p_ren}, 32'h0);
    rst = 1'b0;
    step();

    // Zero-wait write
    issue(1'b1, 28'h000_0010, 4'hF, 32'hDEAD_BEEF);
    check("wr_wen",   {31'b0, p_wen},   32'h1);
    check("wr_ren",   {31'b0, p_ren},   32'h0);
    check("wr_adr",   {8'h0, p_adr},    32'h0000_0010);
    check("wr_sel",   {28'h0, p_sel},   32'hF);
    check("wr_wdata", p_wdata,          32'hDEAD_BEEF);
    check("wr_stall1",{31'b0, stall},   32'h1);
    check("wr_noack1",{31'b0, ack},     32'h0);
    step();
    check("wr_ack",   {31'b0, ack},     32'h1);
    check("wr_stall2",{31'b0, stall},   32'h1);
    check("wr_wen_off",{31'b0, p_wen},  32'h0);
    check("wr_data_kept", rdata,        32'hFFFF_FFFF);
    step();
    check("wr_ack_off",{31'b0, ack},    32'h0);
    check("wr_idle",  {31'b0, stall},   32'h0);

    // Read with three busy cycles
    p_rdata = 32'h1234_5678; p_busy = 1'b1;
    issue(1'b0, 28'h000_0020, 4'hF, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("rd_busy_ren%0d", i), {31'b0, p_ren}, 32'h1);
      check($sformatf("rd_busy_ack%0d", i), {31'b0, ack},   32'h0);
      step();
    end
    check("rd_ren4", {31'b0, p_ren}, 32'h1);
    check("rd_adr",  {8'h0, p_adr},  32'h0000_0020);
    p_busy = 1'b0;
    step();
    check("rd_ack",  {31'b0, ack},   32'h1);
    check("rd_data", rdata,          32'h1234_5678);
    check("rd_ren_off", {31'b0, p_ren}, 32'h0);
    step();
    check("rd_ack_off", {31'b0, ack}, 32'h0);

    // Busy stuck high: error TIMEOUT_CYCLES+2 cycles after acceptance
    p_busy = 1'b1;
    issue(1'b0, 28'h000_0030, 4'hF, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("to_ren%0d", i), {31'b0, p_ren}, 32'h1);
      check($sformatf("to_err%0d", i), {31'b0, err},   32'h0);
      step();
    end
    check("to_err",     {31'b0, err},   32'h1);
    check("to_ack",     {31'b0, ack},   32'h0);
    check("to_ren_off", {31'b0, p_ren}, 32'h0);
    check("to_data",    rdata,          32'hFFFF_FFFF);
    step();
    check("to_err_off", {31'b0, err},   32'h0);
    check("to_idle",    {31'b0, stall}, 32'h0);

    // Cycle abort two cycles into a busy read
    p_rdata = 32'h0BAD_F00D;
    issue(1'b0, 28'h000_0040, 4'hF, 32'h0);
    step();
    step();
    check("ab_ren_before", {31'b0, p_ren}, 32'h1);
    cyc = 1'b0;
    step();
    check("ab_stall", {31'b0, stall}, 32'h0);
    check("ab_ren",   {31'b0, p_ren}, 32'h0);
    check("ab_noack", {31'b0, ack},   32'h0);
    check("ab_noerr", {31'b0, err},   32'h0);
    check("ab_data",  rdata,          32'hFFFF_FFFF);
    p_busy = 1'b0;
    issue(1'b1, 28'h000_0050, 4'h3, 32'hCAFE_F00D);
    check("ab_wr_wen",  {31'b0, p_wen}, 32'h1);
    check("ab_wr_adr",  {8'h0, p_adr},  32'h0000_0050);
    check("ab_wr_sel",  {28'h0, p_sel}, 32'h3);
    step();
    check("ab_wr_ack",  {31'b0, ack},   32'h1);
    step();

    // Zero-wait read, then an out-of-range read
    p_rdata = 32'hA5A5_5A5A;
    issue(1'b0, 28'h000_0070, 4'hF, 32'h0);
    step();
    check("rd2_ack",  {31'b0, ack}, 32'h1);
    check("rd2_data", rdata,        32'hA5A5_5A5A);
    step();
    issue(1'b0, 28'h100_0000, 4'hF, 32'h0);
    check("oob_err",  {31'b0, err},   32'h1);
    check("oob_ack",  {31'b0, ack},   32'h0);
    check("oob_ren",  {31'b0, p_ren}, 32'h0);
    check("oob_wen",  {31'b0, p_wen}, 32'h0);
    check("oob_data", rdata,          32'hFFFF_FFFF);
    step();
    check("oob_err_off", {31'b0, err},   32'h0);
    check("oob_ren_off", {31'b0, p_ren}, 32'h0);

    // Zero-wait read to set data, then reset mid-access
    p_rdata = 32'h5A5A_A5A5;
    issue(1'b0, 28'h000_0074, 4'hF, 32'h0);
    step();
    check("rd3_data", rdata, 32'h5A5A_A5A5);
    step();
    p_busy = 1'b1;
    issue(1'b0, 28'h000_0060, 4'hC, 32'h1111_1111);
    check("rs_ren_before", {31'b0, p_ren}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0; cyc = 1'b0;
    check("rs_ack",   {31'b0, ack},   32'h0);
    check("rs_err",   {31'b0, err},   32'h0);
    check("rs_stall", {31'b0, stall}, 32'h0);
    check("rs_data",  rdata,          32'hFFFF_FFFF);
    check("rs_ren",   {31'b0, p_ren}, 32'h0);
    check("rs_wen",   {31'b0, p_wen}, 32'h0);
    check("rs_adr",   {8'h0, p_adr},  32'h0);
    check("rs_sel",   {28'h0, p_sel}, 32'h0);
    check("rs_wdata", p_wdata,        32'h0);
    step();
    check("rs_idle",  {31'b0, stall}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
